// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with enable, clamped parallel load and terminal count.
// Optional sticky wrap flag: define UPDOWN_MOD_COUNTER_WRAP_FLAG_EN to build wrap_seen as a register.
module updown_mod_counter #(
    parameter int WIDTH   = 3,
    parameter int MAX     = 7,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_seen
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_q;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_count_q;

    // Loads above the modulus saturate so q can never leave 0..MAX.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_V) ? MAX_V : v;
    endfunction

    // Wrap uses explicit compares, so non-power-of-two moduli work.
    function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] cur,
                                                    input logic             dir_up);
        if (dir_up)
            return (cur == MAX_V) ? '0 : cur + WIDTH'(1);
        else
            return (cur == '0) ? MAX_V : cur - WIDTH'(1);
    endfunction

    assign w_at_max  = (r_q == MAX_V);
    assign w_at_zero = (r_q == '0);
    assign w_tc      = en & ~rst & ~load & ((up & w_at_max) | (~up & w_at_zero));
    assign w_load_q  = clamp_load(load_val);
    assign w_count_q = next_count(r_q, up);

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= RST_V;
        else if (load)
            r_q <= w_load_q;
        else if (en)
            r_q <= w_count_q;
    end

`ifdef UPDOWN_MOD_COUNTER_WRAP_FLAG_EN
    logic r_wrap_seen;

    always_ff @(posedge clk) begin
        if (rst || load)
            r_wrap_seen <= 1'b0;
        else if (w_tc)
            r_wrap_seen <= 1'b1;
    end

    assign wrap_seen = r_wrap_seen;
`else
    assign wrap_seen = 1'b0;
`endif

    assign q  = r_q;
    assign tc = w_tc;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Table-driven bench for updown_mod_counter across four parameter sets.
// Instances: 0 = W3/M7/R0, 1 = W3/M5/R5, 2 = W2/M3/R0, 3 = W1/M1/R0.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v [4];
    logic       en_v  [4];
    logic       up_v  [4];
    logic       ld_v  [4];
    logic [2:0] lv_v  [4];

    logic [2:0] q_a, q_b;
    logic [1:0] q_c;
    logic [0:0] q_d;
    logic       tc_v [4];
    logic       ws_v [4];
    logic [2:0] qm   [4];

    assign qm[0] = q_a;
    assign qm[1] = q_b;
    assign qm[2] = {1'b0, q_c};
    assign qm[3] = {2'b00, q_d};

    updown_mod_counter #(.WIDTH(3), .MAX(7), .RST_VAL(0)) u_m7 (
        .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up(up_v[0]), .load(ld_v[0]),
        .load_val(lv_v[0]), .q(q_a), .tc(tc_v[0]), .wrap_seen(ws_v[0]));

    updown_mod_counter #(.WIDTH(3), .MAX(5), .RST_VAL(5)) u_m5 (
        .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up(up_v[1]), .load(ld_v[1]),
        .load_val(lv_v[1]), .q(q_b), .tc(tc_v[1]), .wrap_seen(ws_v[1]));

    updown_mod_counter #(.WIDTH(2), .MAX(3), .RST_VAL(0)) u_m3 (
        .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .up(up_v[2]), .load(ld_v[2]),
        .load_val(lv_v[2][1:0]), .q(q_c), .tc(tc_v[2]), .wrap_seen(ws_v[2]));

    updown_mod_counter #(.WIDTH(1), .MAX(1), .RST_VAL(0)) u_m1 (
        .clk(clk), .rst(rst_v[3]), .en(en_v[3]), .up(up_v[3]), .load(ld_v[3]),
        .load_val(lv_v[3][0:0]), .q(q_d), .tc(tc_v[3]), .wrap_seen(ws_v[3]));

`ifdef UPDOWN_MOD_COUNTER_WRAP_FLAG_EN
    localparam bit FLAG = 1'b1;
`else
    localparam bit FLAG = 1'b0;
`endif

    typedef struct {
        int         d;
        bit         r;
        bit         e;
        bit         u;
        bit         l;
        logic [2:0] v;
        bit         etc;
        logic [2:0] eq;
        bit         ews;
    } vec_t;

    vec_t tv[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int d, input bit r, input bit e, input bit u, input bit l,
                       input logic [2:0] v, input bit etc, input logic [2:0] eq, input bit ews);
        vec_t t;
        t.d = d; t.r = r; t.e = e; t.u = u; t.l = l; t.v = v;
        t.etc = etc; t.eq = eq; t.ews = ews;
        tv.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 4; k++) begin
            rst_v[k] = 1'b0; en_v[k] = 1'b0; up_v[k] = 1'b0;
            ld_v[k]  = 1'b0; lv_v[k] = 3'd0;
        end
    endtask

    initial begin
        // Test 1: up-count M7 through one wrap
        for (int i = 1; i <= 7; i++) add(0, 0, 1, 1, 0, 3'd0, 0, 3'(i), 0);
        add(0, 0, 1, 1, 0, 3'd0, 1, 3'd0, 1);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd1, 1);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd2, 1);
        // Test 2: down-count M5 from RST_VAL 5
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd4, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd3, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd2, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd1, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0);
        add(1, 0, 1, 0, 0, 3'd0, 1, 3'd5, 1);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd4, 1);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd3, 1);
        // Test 3: load, clamp, load beats en at MAX
        add(1, 0, 0, 0, 1, 3'd3, 0, 3'd3, 0);
        add(1, 0, 0, 0, 1, 3'd7, 0, 3'd5, 0);
        add(1, 0, 1, 1, 1, 3'd2, 0, 3'd2, 0);
        // Reset wins over load/en on M5; restart from 5
        add(1, 1, 1, 0, 1, 3'd1, 0, 3'd5, 0);
        add(1, 0, 1, 0, 0, 3'd0, 0, 3'd4, 0);
        // Test 4: enable gating and direction changes on M7
        add(0, 0, 0, 0, 1, 3'd4, 0, 3'd4, 0);
        add(0, 0, 0, 1, 0, 3'd0, 0, 3'd4, 0);
        add(0, 0, 0, 1, 0, 3'd0, 0, 3'd4, 0);
        add(0, 0, 0, 0, 0, 3'd0, 0, 3'd4, 0);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd5, 0);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd6, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 3'd5, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 3'd4, 0);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd5, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 3'd4, 0);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd5, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 3'd4, 0);
        // Test 5: reset at q=7 with load and en high suppresses tc
        add(0, 0, 0, 0, 1, 3'd7, 0, 3'd7, 0);
        add(0, 1, 1, 1, 1, 3'd2, 0, 3'd0, 0);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd1, 0);
        add(0, 0, 1, 1, 0, 3'd0, 0, 3'd2, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 3'd1, 0);
        add(0, 0, 1, 0, 0, 3'd0, 0, 3'd0, 0);
        add(0, 0, 1, 0, 0, 3'd0, 1, 3'd7, 1);
        // Test 6: wrap flag on M3
        add(2, 0, 1, 1, 0, 3'd0, 0, 3'd1, 0);
        add(2, 0, 1, 1, 0, 3'd0, 0, 3'd2, 0);
        add(2, 0, 1, 1, 0, 3'd0, 0, 3'd3, 0);
        add(2, 0, 1, 1, 0, 3'd0, 1, 3'd0, 1);
        add(2, 0, 1, 1, 0, 3'd0, 0, 3'd1, 1);
        add(2, 0, 0, 0, 0, 3'd0, 0, 3'd1, 1);
        add(2, 0, 0, 0, 1, 3'd2, 0, 3'd2, 0);
        add(2, 0, 1, 1, 0, 3'd0, 0, 3'd3, 0);
        add(2, 0, 1, 1, 0, 3'd0, 1, 3'd0, 1);
        add(2, 0, 1, 0, 0, 3'd0, 1, 3'd3, 1);
        add(2, 0, 1, 1, 1, 3'd1, 0, 3'd1, 0);
        // WIDTH=1, MAX=1 toggles in both directions
        add(3, 0, 1, 1, 0, 3'd0, 0, 3'd1, 0);
        add(3, 0, 1, 1, 0, 3'd0, 1, 3'd0, 1);
        add(3, 0, 1, 1, 0, 3'd0, 0, 3'd1, 1);
        add(3, 0, 1, 0, 0, 3'd0, 0, 3'd0, 1);
        add(3, 0, 1, 0, 0, 3'd0, 1, 3'd1, 1);
        add(3, 0, 0, 0, 1, 3'd1, 0, 3'd1, 0);

        idle_all();
        for (int k = 0; k < 4; k++) rst_v[k] = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_q0", -1, qm[0], 3'd0);
        chk("reset_q1", -1, qm[1], 3'd5);
        chk("reset_q2", -1, qm[2], 3'd0);
        chk("reset_q3", -1, qm[3], 3'd0);
        for (int k = 0; k < 4; k++) begin
            chk("reset_tc", k, {2'b00, tc_v[k]}, 3'd0);
            chk("reset_ws", k, {2'b00, ws_v[k]}, 3'd0);
        end

        foreach (tv[i]) begin
            idle_all();
            rst_v[tv[i].d] = tv[i].r;
            en_v[tv[i].d]  = tv[i].e;
            up_v[tv[i].d]  = tv[i].u;
            ld_v[tv[i].d]  = tv[i].l;
            lv_v[tv[i].d]  = tv[i].v;
            @(negedge clk);
            chk("tc", i, {2'b00, tc_v[tv[i].d]}, {2'b00, tv[i].etc});
            @(posedge clk);
            #1;
            chk("q", i, qm[tv[i].d], tv[i].eq);
            chk("wrap_seen", i, {2'b00, ws_v[tv[i].d]}, {2'b00, tv[i].ews & FLAG});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
